// File: rtl/stream_upsize_packer.sv
// Narrow-to-wide stream packer: gathers beats into lanes, then presents
// one wide word with keep/last; collect and send phases never overlap.
module stream_upsize_packer #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DATA_RATIO = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [T_DATA_WIDTH-1:0]              s_data_i,
  input  logic                                 s_valid_i,
  input  logic                                 s_last_i,
  output logic                                 s_ready_o,
  output logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] m_data_o,
  output logic [T_DATA_RATIO-1:0]              m_keep_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i
);

  localparam int CW = $clog2(T_DATA_RATIO);
  localparam int DW = T_DATA_WIDTH * T_DATA_RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(T_DATA_RATIO - 1);

  typedef enum logic {
    COLLECT,
    SEND
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DW-1:0]           data;
  logic [T_DATA_RATIO-1:0] keep;
  logic                    last;

  assign s_ready_o = (state == COLLECT);
  assign m_valid_o = (state == SEND);
  assign m_data_o  = data;
  assign m_keep_o  = keep;
  assign m_last_o  = last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= COLLECT;
      cnt   <= '0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (s_valid_i) begin
            for (int k = 0; k < T_DATA_RATIO; k++) begin
              if (cnt == CW'(k)) begin
                data[k*T_DATA_WIDTH +: T_DATA_WIDTH] <= s_data_i;
                keep[k] <= 1'b1;
              end
            end
            // counter saturates on the final lane; SEND clears it anyway
            if (cnt != LAST_LANE) begin
              cnt <= cnt + CW'(1);
            end
            if (cnt == LAST_LANE || s_last_i) begin
              state <= SEND;
              last  <= s_last_i;
            end
          end
        end
        SEND: begin
          if (m_ready_i) begin
            state <= COLLECT;
            cnt   <= '0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/stream_upsize_packer.md
STREAM_UPSIZE_PACKER -- requirements
Module: stream_upsize_packer

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 8, width in bits of one narrow input beat.
REQ-002 SHALL have parameter T_DATA_RATIO, default 4, number of narrow beats per wide output word; legal values are 2 or greater.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 s_data_i  input  T_DATA_WIDTH  narrow input beat.
REQ-006 s_valid_i  input  1  input beat valid.
REQ-007 s_last_i  input  1  marks the final beat of a packet.
REQ-008 s_ready_o  output  1  block accepts the input beat.
REQ-009 m_data_o  output  T_DATA_WIDTH*T_DATA_RATIO  packed word; lane k is bits [k*T_DATA_WIDTH +: T_DATA_WIDTH].
REQ-010 m_keep_o  output  T_DATA_RATIO  per-lane valid mask; bit k set means lane k holds a beat.
REQ-011 m_last_o  output  1  word closes a packet.
REQ-012 m_valid_o  output  1  output word valid.
REQ-013 m_ready_i  input  1  downstream accepts the word.

Function
REQ-014 An input transfer SHALL occur when s_valid_i and s_ready_o are both 1 on a rising edge; an output transfer SHALL occur when m_valid_o and m_ready_i are both 1.
REQ-015 The block SHALL use a two-state FSM: COLLECT and SEND.
REQ-016 Lane index counter: width clog2(T_DATA_RATIO), range 0..T_DATA_RATIO-1; it never wraps past T_DATA_RATIO-1.
REQ-017 In COLLECT: s_ready_o = 1 and m_valid_o = 0.
REQ-018 On each input transfer in COLLECT: the beat is written to lane[cnt], keep bit cnt is set, and cnt increments.
REQ-019 COLLECT -> SEND occurs on an input transfer where cnt == T_DATA_RATIO-1 or s_last_i = 1; m_last_o is registered as s_last_i of that beat.
REQ-020 In SEND: s_ready_o = 0, m_valid_o = 1; m_data_o, m_keep_o and m_last_o are held stable until the output transfer.
REQ-021 On the output transfer in SEND: next state is COLLECT, cnt = 0, keep = 0, data lanes = 0, m_last_o = 0.
REQ-022 Latency: m_valid_o rises in the cycle after the closing input beat is accepted.
REQ-023 Throughput: at most one wide word per T_DATA_RATIO+1 cycles; input and output do not overlap.
REQ-024 Lanes not written in a short (s_last_i-terminated) word SHALL read 0, with their keep bits 0.
REQ-025 m_keep_o SHALL always be contiguous from bit 0 (for example 0001, 0011, 0111, 1111).
REQ-026 A single-beat packet (s_last_i on the first beat) SHALL produce keep = 0...01 and m_last_o = 1.
REQ-027 A full word whose final beat has s_last_i = 0 SHALL have m_last_o = 0; the packet continues in the next word at lane 0.
REQ-028 In SEND, s_valid_i and s_data_i SHALL be ignored; the upstream holds its beat because s_ready_o = 0.
REQ-029 In COLLECT, m_ready_i SHALL be ignored.

Reset
REQ-030 While rst_i = 1 at a rising edge: state = COLLECT, cnt = 0, m_data_o = 0, m_keep_o = 0, m_last_o = 0, m_valid_o = 0.
REQ-031 s_ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-word, in either COLLECT or SEND, SHALL discard the partial or pending word with no output transfer.
REQ-033 Reset has priority over any simultaneous input or output transfer.

Verification (T_DATA_WIDTH=8, T_DATA_RATIO=4)
REQ-034 Beats 0x11, 0x22, 0x33, 0x44 with last on 0x44, m_ready_i = 1 -> m_data_o = 0x44332211, m_keep_o = 0xF, m_last_o = 1, one cycle after 0x44 is accepted.
REQ-035 Beats 0xAA, 0xBB with last on 0xBB -> m_data_o = 0x0000BBAA, m_keep_o = 0x3, m_last_o = 1.
REQ-036 Six beats 0x01..0x06 with last on 0x06 -> word 1 is 0x04030201 with keep F and last 0; word 2 is 0x00000605 with keep 3 and last 1.
REQ-037 m_ready_i = 0 for 5 cycles in SEND while s_valid_i = 1 -> outputs stable, s_ready_o = 0, no beat lost; the next beat lands in lane 0 after the transfer.
REQ-038 rst_i pulsed after 2 beats accepted -> no output word; a following single beat 0x5A with last gives 0x0000005A, keep 1.
REQ-039 Random valid/ready stress against a scoreboard -> every input byte appears once, in order, in the correct lane, and keep/last match packet boundaries.
